alarm_sounder: RTL and testbench



---
 rtl/clock_pkg.sv | 33 +++
 rtl/tone_gen.sv | 38 +++
 rtl/alarm_sounder.sv | 159 +++++++++++++++
 tb/tb_alarm_sounder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Purpose: constants shared by the clock top level and alarm_sounder (FSM encoding, tone/pattern defaults).
// Latency: n/a (package only).
// Backpressure: n/a.
package clock_pkg;

    // Alert sequencer state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEEP  = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    // Defaults at a 1 kHz system clock.
    localparam int TONE_HALF_T_DEF = 1;      // 500 Hz timer tone
    localparam int TONE_HALF_A_DEF = 2;      // 250 Hz alarm tone
    localparam int BEEP_LEN_DEF    = 100;
    localparam int GAP_LEN_DEF     = 100;
    localparam int PAUSE_LEN_DEF   = 500;
    localparam int BEEPS_DEF       = 3;
    localparam int TIMEOUT_CYC_DEF = 60000;

    localparam int DUR_W = 16;

    // Pattern lengths must fit the 16-bit duration counter and be non-zero.
    function automatic bit is_len_ok(input int v);
        return (v >= 1) && (v < 65536);
    endfunction

    // Tone half-periods travel on a 2-bit bus into tone_gen.
    function automatic bit is_half_ok(input int v);
        return (v >= 1) && (v <= 3);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Purpose: square-wave generator with a programmable half-period of 1..3 clk cycles.
// Latency: wave is registered; after clr it reads 0 and first toggles after `half` enabled cycles.
// Backpressure: none; en simply freezes the phase and counter.
//
// Ports: clk, rst (async, active-low), en (advance the tone), clr (restart phase/counter at 0,
//        has priority over en), half (half-period in cycles), wave (registered phase).
module tone_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] half,
    output logic       wave
);

    logic [1:0] cnt;
    logic [1:0] half_m1;

    assign half_m1 = half - 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= 2'd0;
            wave <= 1'b0;
        end else if (clr) begin
            cnt  <= 2'd0;
            wave <= 1'b0;
        end else if (en) begin
            if (cnt == half_m1) begin
                cnt  <= 2'd0;
                wave <= ~wave;
            end else begin
                cnt <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_sounder.sv
// Purpose: turns timer/alarm request levels into a repeating beep-burst on the piezo and red LED.
// Latency: 1 cycle from a sampled start/exit condition to all outputs; outputs decode registered state.
// Backpressure: none; the block free-runs while a request is held, stop edge or request low silences it.
//
// Ports: clk, rst (async, active-low), timer_req / alarm_req (request levels, timer wins a tie),
//        btn_stop (debounced, acts on rising edge), piezo_out (tone during BEEP), rgb_r (4'hF during
//        BEEP), active (any non-IDLE state).
// Build option: define ALARM_SOUNDER_TIMEOUT_EN to auto-silence after TIMEOUT_CYC active cycles.
module alarm_sounder
    import clock_pkg::*;
#(
    parameter int TONE_HALF_T = TONE_HALF_T_DEF,
    parameter int TONE_HALF_A = TONE_HALF_A_DEF,
    parameter int BEEP_LEN    = BEEP_LEN_DEF,
    parameter int GAP_LEN     = GAP_LEN_DEF,
    parameter int PAUSE_LEN   = PAUSE_LEN_DEF,
    parameter int BEEPS       = BEEPS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timer_req,
    input  logic       alarm_req,
    input  logic       btn_stop,
    output logic       piezo_out,
    output logic [3:0] rgb_r,
    output logic       active
);

    localparam int IDX_W = $clog2(BEEPS + 1);

    localparam logic [DUR_W-1:0] BEEP_LAST  = DUR_W'(BEEP_LEN - 1);
    localparam logic [DUR_W-1:0] GAP_LAST   = DUR_W'(GAP_LEN - 1);
    localparam logic [DUR_W-1:0] PAUSE_LAST = DUR_W'(PAUSE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BEEPS - 1);
    localparam logic [1:0]       HALF_T     = 2'(TONE_HALF_T);
    localparam logic [1:0]       HALF_A     = 2'(TONE_HALF_A);

    if (!is_len_ok(BEEP_LEN) || !is_len_ok(GAP_LEN) || !is_len_ok(PAUSE_LEN) ||
        !is_len_ok(BEEPS) || !is_half_ok(TONE_HALF_T) || !is_half_ok(TONE_HALF_A) ||
        (TIMEOUT_CYC < 1) || (TIMEOUT_CYC >= 131072)) begin : g_bad_param
        $error("alarm_sounder: parameter out of range");
    end

    logic [1:0]       state, state_nxt;
    logic [DUR_W-1:0] dur, dur_nxt;
    logic [IDX_W-1:0] beep_idx, idx_nxt;
    logic             req, req_d, stop_d, src_timer;
    logic             stop_edge, start, timeout, leave;
    logic             wave;

    assign req       = timer_req | alarm_req;
    assign stop_edge = btn_stop & ~stop_d;
    // A stop edge in the same cycle as a request edge keeps the block silent.
    assign start     = (state == ST_IDLE) & req & ~req_d & ~stop_edge;
    assign leave     = (state != ST_IDLE) & (stop_edge | ~req | timeout);

`ifdef ALARM_SOUNDER_TIMEOUT_EN
    localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYC - 1);
    logic [16:0] to_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= 17'd0;
        else if (start)
            to_cnt <= 17'd0;
        else if (state != ST_IDLE)
            to_cnt <= to_cnt + 17'd1;
    end

    // Fires on the edge that would make the count reach TIMEOUT_CYC, so exactly
    // TIMEOUT_CYC cycles are spent outside IDLE.
    assign timeout = (to_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        dur_nxt   = dur;
        idx_nxt   = beep_idx;
        if (leave) begin
            state_nxt = ST_IDLE;
            dur_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_BEEP;
                        dur_nxt   = '0;
                        idx_nxt   = '0;
                    end
                end
                ST_BEEP: begin
                    if (dur == BEEP_LAST) begin
                        dur_nxt   = '0;
                        state_nxt = (beep_idx == IDX_LAST) ? ST_PAUSE : ST_GAP;
                    end else begin
                        dur_nxt = dur + DUR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (dur == GAP_LAST) begin
                        dur_nxt   = '0;
                        idx_nxt   = beep_idx + IDX_W'(1);
                        state_nxt = ST_BEEP;
                    end else begin
                        dur_nxt = dur + DUR_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (dur == PAUSE_LAST) begin
                        dur_nxt   = '0;
                        idx_nxt   = '0;
                        state_nxt = ST_BEEP;
                    end else begin
                        dur_nxt = dur + DUR_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            dur       <= '0;
            beep_idx  <= '0;
            req_d     <= 1'b0;
            stop_d    <= 1'b0;
            src_timer <= 1'b0;
        end else begin
            state    <= state_nxt;
            dur      <= dur_nxt;
            beep_idx <= idx_nxt;
            req_d    <= req;
            stop_d   <= btn_stop;
            // Source is frozen for the whole episode; later edges on the other input are ignored.
            if (start)
                src_timer <= timer_req;
        end
    end

    tone_gen u_tone (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_BEEP),
        .clr  ((state_nxt == ST_BEEP) && (state != ST_BEEP)),
        .half (src_timer ? HALF_T : HALF_A),
        .wave (wave)
    );

    assign piezo_out = (state == ST_BEEP) & wave;
    assign rgb_r     = {4{state == ST_BEEP}};
    assign active    = (state != ST_IDLE);

endmodule

// File: tb/tb_alarm_sounder.sv
// Purpose: directed self-checking bench for alarm_sounder with default parameters.
// Latency: checks outputs 1 ns after each rising clk edge.
// Backpressure: n/a.
module tb_alarm_sounder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       timer_req = 1'b0;
    logic       alarm_req = 1'b0;
    logic       btn_stop = 1'b0;
    logic       piezo_out;
    logic [3:0] rgb_r;
    logic       active;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_sounder dut (
        .clk       (clk),
        .rst       (rst),
        .timer_req (timer_req),
        .alarm_req (alarm_req),
        .btn_stop  (btn_stop),
        .piezo_out (piezo_out),
        .rgb_r     (rgb_r),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected {active, rgb_r, piezo_out} k cycles after the start edge while a
    // request is held: beeps of 100 at offsets 0/200/400 in a 1000-cycle burst.
    function automatic logic [5:0] exp_out(input int k, input int half);
        int pos;
        logic [5:0] r;
        pos = k % 1000;
        r = 6'b1_0000_0;
        for (int b = 0; b < 3; b++) begin
            if (pos >= b * 200 && pos < b * 200 + 100) begin
                r[4:1] = 4'hF;
                r[0]   = ((pos - b * 200) / half) % 2 == 1;
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        #2;
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want %b", {active, rgb_r, piezo_out}, 6'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle_after_release: got %b, want %b", {active, rgb_r, piezo_out}, 6'b0);
        end
    endtask

    task automatic test_alarm_pattern();
        alarm_req = 1'b1;
        tick(1);
        for (int k = 0; k < 1100; k++) begin
            n_checks++;
            if ({active, rgb_r, piezo_out} !== exp_out(k, 2)) begin
                n_fail++;
                $display("FAIL alarm_pattern k=%0d: got %b, want %b", k, {active, rgb_r, piezo_out}, exp_out(k, 2));
            end
            tick(1);
        end
        alarm_req = 1'b0;
        tick(1);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL alarm_release: got %b, want %b", {active, rgb_r, piezo_out}, 6'b0);
        end
    endtask

    task automatic test_timer_priority();
        timer_req = 1'b1;
        alarm_req = 1'b1;
        tick(1);
        for (int k = 0; k < 300; k++) begin
            if (k == 100) timer_req = 1'b0;   // alarm keeps req high; tone must stay the timer's
            n_checks++;
            if ({active, rgb_r, piezo_out} !== exp_out(k, 1)) begin
                n_fail++;
                $display("FAIL timer_priority k=%0d: got %b, want %b", k, {active, rgb_r, piezo_out}, exp_out(k, 1));
            end
            tick(1);
        end
        alarm_req = 1'b0;
        tick(1);
    endtask

    task automatic test_source_latch();
        alarm_req = 1'b1;
        tick(1);
        for (int k = 0; k < 300; k++) begin
            if (k == 10) timer_req = 1'b1;
            n_checks++;
            if ({active, rgb_r, piezo_out} !== exp_out(k, 2)) begin
                n_fail++;
                $display("FAIL source_latch k=%0d: got %b, want %b", k, {active, rgb_r, piezo_out}, exp_out(k, 2));
            end
            tick(1);
        end
        timer_req = 1'b0;
        alarm_req = 1'b0;
        tick(1);
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL source_latch_release: active got %b, want 0", active);
        end
    endtask

    task automatic test_stop();
        alarm_req = 1'b1;
        tick(1);
        tick(50);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== exp_out(50, 2)) begin
            n_fail++;
            $display("FAIL stop_pre: got %b, want %b", {active, rgb_r, piezo_out}, exp_out(50, 2));
        end
        btn_stop = 1'b1;
        tick(1);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL stop_silences: got %b, want %b", {active, rgb_r, piezo_out}, 6'b0);
        end
        btn_stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_checks++;
            if (active !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_no_restart i=%0d: active got %b, want 0", i, active);
            end
        end
        alarm_req = 1'b0;
        tick(1);
        alarm_req = 1'b1;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({active, rgb_r, piezo_out} !== exp_out(k, 2)) begin
                n_fail++;
                $display("FAIL stop_rearm k=%0d: got %b, want %b", k, {active, rgb_r, piezo_out}, exp_out(k, 2));
            end
            tick(1);
        end
        alarm_req = 1'b0;
        tick(1);
    endtask

    task automatic test_drop_in_gap();
        alarm_req = 1'b1;
        tick(1);
        tick(150);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b1_0000_0) begin
            n_fail++;
            $display("FAIL gap_state: got %b, want %b", {active, rgb_r, piezo_out}, 6'b1_0000_0);
        end
        alarm_req = 1'b0;
        tick(1);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL gap_drop: got %b, want %b", {active, rgb_r, piezo_out}, 6'b0);
        end
    endtask

    task automatic test_stop_start_same_cycle();
        alarm_req = 1'b1;
        btn_stop  = 1'b1;
        tick(1);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL stop_start_same: got %b, want %b", {active, rgb_r, piezo_out}, 6'b0);
        end
        btn_stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_checks++;
            if (active !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_start_hold i=%0d: active got %b, want 0", i, active);
            end
        end
        alarm_req = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_beep();
        alarm_req = 1'b1;
        tick(1);
        tick(30);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== exp_out(30, 2)) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got %b, want %b", {active, rgb_r, piezo_out}, exp_out(30, 2));
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %b, want %b", {active, rgb_r, piezo_out}, 6'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({active, rgb_r, piezo_out} !== exp_out(k, 2)) begin
                n_fail++;
                $display("FAIL rst_release_start k=%0d: got %b, want %b", k, {active, rgb_r, piezo_out}, exp_out(k, 2));
            end
            tick(1);
        end
        alarm_req = 1'b0;
        tick(1);
    endtask

    task automatic test_long_run();
        alarm_req = 1'b1;
        tick(1);
        tick(59999);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== exp_out(59999, 2)) begin
            n_fail++;
            $display("FAIL long_59999: got %b, want %b", {active, rgb_r, piezo_out}, exp_out(59999, 2));
        end
        tick(1);
`ifdef ALARM_SOUNDER_TIMEOUT_EN
        n_checks++;
        if ({active, rgb_r, piezo_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL timeout_60000: got %b, want %b", {active, rgb_r, piezo_out}, 6'b0);
        end
        tick(10);
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_no_restart: active got %b, want 0", active);
        end
`else
        n_checks++;
        if ({active, rgb_r, piezo_out} !== exp_out(60000, 2)) begin
            n_fail++;
            $display("FAIL long_60000: got %b, want %b", {active, rgb_r, piezo_out}, exp_out(60000, 2));
        end
        tick(10000);
        n_checks++;
        if ({active, rgb_r, piezo_out} !== exp_out(70000, 2)) begin
            n_fail++;
            $display("FAIL long_70000: got %b, want %b", {active, rgb_r, piezo_out}, exp_out(70000, 2));
        end
`endif
        alarm_req = 1'b0;
        tick(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alarm_pattern();
        test_timer_priority();
        test_source_latch();
        test_stop();
        test_drop_in_gap();
        test_stop_start_same_cycle();
        test_reset_mid_beep();
        test_long_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
